// File: rtl/arm_pkg.sv
// Shared types for the ARM core pipeline controller.
// Holds the controller FSM state encoding and the register-number width.
package arm_pkg;

    localparam int REG_W = 4;

    typedef enum logic [0:0] {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } pipe_state_t;

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// hazard_detect: RAW compare of ID sources against the EXE and MEM destinations.
// Ports: src1/src2 + hasSrc1/Two_src (ID reads), exe_*/mem_* (writers), raw_x/raw_m.
module hazard_detect
    import arm_pkg::*;
(
    input  logic [REG_W-1:0] src1,
    input  logic [REG_W-1:0] src2,
    input  logic             hasSrc1,
    input  logic             Two_src,
    input  logic [REG_W-1:0] exe_dest,
    input  logic             exe_wb_en,
    input  logic [REG_W-1:0] mem_dest,
    input  logic             mem_wb_en,
    output logic             raw_x,
    output logic             raw_m
);

    assign raw_x = exe_wb_en &
                   ((hasSrc1 & (src1 == exe_dest)) |
                    (Two_src & (src2 == exe_dest)));

    assign raw_m = mem_wb_en &
                   ((hasSrc1 & (src1 == mem_dest)) |
                    (Two_src & (src2 == mem_dest)));

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: hazard/freeze/flush/mem_freeze generation, memory-wait FSM with
// timeout watchdog (sticky mem_err) and saturating stall_cnt.
// Inputs: ID sources, EXE/MEM destinations, br_taken, mem_req/mem_ready.
// Outputs: hazard, freeze, flush, mem_freeze, mem_err, stall_cnt[CNT_W].
// Macro PIPE_FORWARDING_EN: when defined only load-use raises hazard.
module pipe_ctrl
    import arm_pkg::*;
#(
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] src1,
    input  logic [REG_W-1:0] src2,
    input  logic             hasSrc1,
    input  logic             Two_src,
    input  logic [REG_W-1:0] exe_dest,
    input  logic             exe_wb_en,
    input  logic             exe_mem_r_en,
    input  logic [REG_W-1:0] mem_dest,
    input  logic             mem_wb_en,
    input  logic             mem_req,
    input  logic             mem_ready,
    input  logic             br_taken,
    output logic             hazard,
    output logic             freeze,
    output logic             flush,
    output logic             mem_freeze,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [15:0] TMO_LAST = 16'(MEM_TIMEOUT - 1);

    pipe_state_t      state_q, state_d;
    logic [15:0]      wait_q, wait_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] stall_q, stall_d;

    logic raw_x, raw_m, raw_hit, mem_stall;
    logic hz, frz, fl, mfrz;

    hazard_detect u_hd (
        .src1      (src1),
        .src2      (src2),
        .hasSrc1   (hasSrc1),
        .Two_src   (Two_src),
        .exe_dest  (exe_dest),
        .exe_wb_en (exe_wb_en),
        .mem_dest  (mem_dest),
        .mem_wb_en (mem_wb_en),
        .raw_x     (raw_x),
        .raw_m     (raw_m)
    );

`ifdef PIPE_FORWARDING_EN
    // Forwarding covers everything but a load result still in EXE.
    logic unused_raw_m;
    assign unused_raw_m = raw_m;
    assign raw_hit = raw_x & exe_mem_r_en;
`else
    logic unused_ld;
    assign unused_ld = exe_mem_r_en;
    assign raw_hit = raw_x | raw_m;
`endif

    assign mem_stall = mem_req & ~mem_ready;

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        err_d   = err_q;
        hz      = 1'b0;
        frz     = 1'b0;
        fl      = 1'b0;
        mfrz    = 1'b0;
        unique case (state_q)
            RUN: begin
                if (mem_stall) begin
                    mfrz    = 1'b1;
                    frz     = 1'b1;
                    state_d = MEM_WAIT;
                    wait_d  = '0;
                end else if (br_taken) begin
                    // ID instruction is squashed, its hazard is moot.
                    fl = 1'b1;
                end else if (raw_hit) begin
                    hz  = 1'b1;
                    frz = 1'b1;
                end
            end
            MEM_WAIT: begin
                // Branch in EXE stays frozen; it flushes on return to RUN.
                mfrz = 1'b1;
                frz  = 1'b1;
                if (mem_ready) begin
                    state_d = RUN;
                    wait_d  = '0;
                end else if (wait_q == TMO_LAST) begin
                    err_d   = 1'b1;
                    state_d = RUN;
                    wait_d  = '0;
                end else begin
                    wait_d = wait_q + 16'd1;
                end
            end
            default: begin
                state_d = RUN;
                wait_d  = '0;
            end
        endcase
    end

    always_comb begin
        stall_d = stall_q;
        if (frz && (stall_q != {CNT_W{1'b1}}))
            stall_d = stall_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            wait_q  <= '0;
            err_q   <= 1'b0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            err_q   <= err_d;
            stall_q <= stall_d;
        end
    end

    // Everything reads 0 while reset is held, even before the first edge.
    assign hazard     = hz & ~rst;
    assign freeze     = frz & ~rst;
    assign flush      = fl & ~rst;
    assign mem_freeze = mfrz & ~rst;
    assign mem_err    = err_q & ~rst;
    assign stall_cnt  = rst ? '0 : stall_q;

endmodule
